aes_multiblock_fsm: RTL and testbench
=====================================

// Module: aes_multiblock_fsm
// PURPOSE
// Control FSM for the AES HWPE, successor of the single-block controller. Runs one job of
// N 128-bit blocks (N from the register file) through the plaintext source and ciphertext sink streamers.
// Counts blocks completed by the engine, waits for the sink to drain, and runs a per-block watchdog.
// Reports done, error and progress to the slave.
// PARAMETERS
// CNT_W      16  width of block count / progress counter (max N = 2**CNT_W-1)
// ADDR_W     32  streamer base-address width
// DATA_W     32  streamer word width; WPB = 128/DATA_W words per block (DATA_W in {32,64,128})
// WDOG_W     10  watchdog counter width; timeout = 2**WDOG_W-1 cycles without a block_done
// PORTS
// clk                  in   1       clock, all logic on posedge
// reset_n              in   1       asynchronous active-low reset
// clear                in   1       synchronous soft clear, returns to IDLE
// start_i              in   1       slave start pulse
// nb_blocks_i          in   CNT_W   block count N (hwpe_params[1])
// src_base_i           in   ADDR_W  plaintext base address (hwpe_params[0])
// dst_base_i           in   ADDR_W  ciphertext base address (hwpe_params[3])
// src_ready_start_i    in   1       source streamer ready_start
// snk_ready_start_i    in   1       sink streamer ready_start
// snk_done_i           in   1       sink streamer done pulse (all words written)
// eng_block_done_i     in   1       engine pulse: one ciphertext block produced
// src_req_start_o      out  1       source req_start
// snk_req_start_o      out  1       sink req_start
// src_base_o/dst_base_o out ADDR_W  latched base addresses
// line_length_o        out  CNT_W+3 N*WPB words, shared by source and sink (trans_size=1, strides 0)
// eng_clear_o          out  1       engine clear
// eng_start_o          out  1       engine start
// eng_enable_o         out  1       engine enable
// done_o               out  1       one-cycle job-done pulse to slave
// err_o                out  1       sticky error: bit set on zero-length job or watchdog timeout
// busy_o               out  1       high in any state except IDLE
// blocks_done_o        out  CNT_W   blocks completed in current/last job
// BEHAVIOUR
// - Reset (reset_n=0): state IDLE; all outputs 0 except eng_clear_o=1 (IDLE output); counters 0.
// - States IDLE, STARTING, WORKING, DRAIN, FINISHED; registered state, Moore outputs.
// - IDLE: eng_clear_o=1. On start_i: latch N, bases; clear blocks_done_o, err_o, wdog, snk_seen.
//   N==0 -> FINISHED with err_o=1; else -> STARTING. start_i outside IDLE is ignored.
// - STARTING: eng_start_o=1, src/snk_req_start_o=1, held until both ready_start_i are high in the
//   same cycle; then -> WORKING. req_start is not asserted in any other state.
// - WORKING: eng_enable_o=1. Each eng_block_done_i increments blocks_done_o (saturating at N).
//   When increment makes count==N -> DRAIN the next cycle. wdog counts cycles, resets on each
//   block_done; reaching all-ones -> FINISHED with err_o=1 (count frozen).
// - snk_done_i is captured in a snk_seen flag in WORKING or DRAIN (same-cycle as last block_done ok).
// - DRAIN: eng_enable_o=1; snk_seen (or snk_done_i this cycle) -> FINISHED; watchdog also active.
// - FINISHED: eng_enable_o=1, done_o=1 for exactly one cycle; -> IDLE.
// - clear has priority over all transitions: next state IDLE, counters/flags cleared, no done_o.
// - line_length_o = N_latched * WPB, computed at full width (no overflow); bases stable while busy.
// - Reset asserted mid-job: immediate return to IDLE, no done_o; err_o cleared.
// TESTING
// - N=4, DATA_W=32, ready_start high 3 cycles after req -> line_length_o=16, 4 block_done, snk_done -> one done_o, blocks_done_o=4, err_o=0.
// - N=0 start -> STARTING skipped, done_o one cycle after start, err_o=1, no req_start.
// - N=2, ready_start staggered (src cyc 2, snk cyc 5) -> WORKING entered only after cycle 5.
// - N=1, block_done and snk_done same cycle -> DRAIN 1 cycle, done_o, err_o=0.
// - N=3, engine stalls after block 1 for 1023 cycles -> done_o, err_o=1, blocks_done_o=1.
// - clear (and separately reset_n=0) during WORKING of N=8 -> IDLE, no done_o; second start_i runs clean.

Source files
------------

// File: rtl/aes_multiblock_fsm.sv
// aes_multiblock_fsm: control FSM for the multi-block AES HWPE.
// Starts the plaintext source / ciphertext sink streamers, lets the engine run
// N blocks, counts finished blocks, waits for the sink to drain and guards the
// job with a per-block watchdog. Reports done, error and progress to the slave.
module aes_multiblock_fsm #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WDOG_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  nb_blocks_i,
   input  logic [ADDR_W-1:0] src_base_i,
   input  logic [ADDR_W-1:0] dst_base_i,
   input  logic              src_ready_start_i,
   input  logic              snk_ready_start_i,
   input  logic              snk_done_i,
   input  logic              eng_block_done_i,
   output logic              src_req_start_o,
   output logic              snk_req_start_o,
   output logic [ADDR_W-1:0] src_base_o,
   output logic [ADDR_W-1:0] dst_base_o,
   output logic [CNT_W+2:0]  line_length_o,
   output logic              eng_clear_o,
   output logic              eng_start_o,
   output logic              eng_enable_o,
   output logic              done_o,
   output logic              err_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  blocks_done_o
);

   localparam int WPB  = 128 / DATA_W;
   localparam int LL_W = CNT_W + 3;

   typedef enum logic [2:0] {
      IDLE,
      STARTING,
      WORKING,
      DRAIN,
      FINISHED
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    n_reg, n_next;
   logic [ADDR_W-1:0]   src_base_reg, src_base_next;
   logic [ADDR_W-1:0]   dst_base_reg, dst_base_next;
   logic [CNT_W-1:0]    blocks_reg, blocks_next;
   logic                err_reg, err_next;
   logic [WDOG_W-1:0]   wdog_reg, wdog_next;
   logic                snk_seen_reg, snk_seen_next;

   logic [CNT_W-1:0]    blocks_inc;
   logic                wdog_expired;

   assign blocks_inc   = blocks_reg + CNT_W'(1);
   assign wdog_expired = &wdog_reg;

   // State and job registers; asynchronous reset returns to IDLE with all counters cleared
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         n_reg        <= '0;
         src_base_reg <= '0;
         dst_base_reg <= '0;
         blocks_reg   <= '0;
         err_reg      <= 1'b0;
         wdog_reg     <= '0;
         snk_seen_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         n_reg        <= n_next;
         src_base_reg <= src_base_next;
         dst_base_reg <= dst_base_next;
         blocks_reg   <= blocks_next;
         err_reg      <= err_next;
         wdog_reg     <= wdog_next;
         snk_seen_reg <= snk_seen_next;
      end
   end

   // Next-state, job bookkeeping and Moore outputs decoded from the current state
   always_comb begin
      state_next      = state_reg;
      n_next          = n_reg;
      src_base_next   = src_base_reg;
      dst_base_next   = dst_base_reg;
      blocks_next     = blocks_reg;
      err_next        = err_reg;
      wdog_next       = wdog_reg;
      snk_seen_next   = snk_seen_reg;
      src_req_start_o = 1'b0;
      snk_req_start_o = 1'b0;
      eng_clear_o     = 1'b0;
      eng_start_o     = 1'b0;
      eng_enable_o    = 1'b0;
      done_o          = 1'b0;
      busy_o          = 1'b1;

      case (state_reg)
         IDLE: begin
            eng_clear_o = 1'b1;
            busy_o      = 1'b0;
            if (start_i) begin
               n_next        = nb_blocks_i;
               src_base_next = src_base_i;
               dst_base_next = dst_base_i;
               blocks_next   = '0;
               err_next      = 1'b0;
               wdog_next     = '0;
               snk_seen_next = 1'b0;
               if (nb_blocks_i == '0) begin
                  // an empty job is reported as an error without touching the streamers
                  err_next   = 1'b1;
                  state_next = FINISHED;
               end else begin
                  state_next = STARTING;
               end
            end
         end

         STARTING: begin
            eng_start_o     = 1'b1;
            src_req_start_o = 1'b1;
            snk_req_start_o = 1'b1;
            if (src_ready_start_i && snk_ready_start_i) begin
               state_next = WORKING;
            end
         end

         WORKING: begin
            eng_enable_o = 1'b1;
            if (snk_done_i) begin
               snk_seen_next = 1'b1;
            end
            if (eng_block_done_i) begin
               wdog_next = '0;
               if (blocks_reg != n_reg) begin
                  blocks_next = blocks_inc;
               end
               if (blocks_inc == n_reg) begin
                  state_next = DRAIN;
               end
            end else if (wdog_expired) begin
               // engine stalled: abort with the progress count frozen
               err_next   = 1'b1;
               state_next = FINISHED;
            end else begin
               wdog_next = wdog_reg + WDOG_W'(1);
            end
         end

         DRAIN: begin
            eng_enable_o = 1'b1;
            if (snk_done_i) begin
               snk_seen_next = 1'b1;
            end
            if (snk_seen_reg || snk_done_i) begin
               state_next = FINISHED;
            end else if (eng_block_done_i) begin
               wdog_next = '0;
            end else if (wdog_expired) begin
               err_next   = 1'b1;
               state_next = FINISHED;
            end else begin
               wdog_next = wdog_reg + WDOG_W'(1);
            end
         end

         FINISHED: begin
            eng_enable_o = 1'b1;
            done_o       = 1'b1;
            state_next   = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // soft clear overrides any transition chosen above
      if (clear) begin
         state_next    = IDLE;
         blocks_next   = '0;
         err_next      = 1'b0;
         wdog_next     = '0;
         snk_seen_next = 1'b0;
      end
   end

   assign src_base_o    = src_base_reg;
   assign dst_base_o    = dst_base_reg;
   assign blocks_done_o = blocks_reg;
   assign err_o         = err_reg;
   // full-width product so the largest N never wraps
   assign line_length_o = LL_W'(n_reg) * LL_W'(WPB);

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
// tb_aes_multiblock_fsm: scoreboard bench for the multi-block AES control FSM.
// Drivers push the expected job outcome into a queue; a monitor pops and compares
// on every done_o pulse.
module tb_aes_multiblock_fsm;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic        start_i;
   logic [15:0] nb_blocks_i;
   logic [31:0] src_base_i;
   logic [31:0] dst_base_i;
   logic        src_ready_start_i;
   logic        snk_ready_start_i;
   logic        snk_done_i;
   logic        eng_block_done_i;
   logic        src_req_start_o;
   logic        snk_req_start_o;
   logic [31:0] src_base_o;
   logic [31:0] dst_base_o;
   logic [18:0] line_length_o;
   logic        eng_clear_o;
   logic        eng_start_o;
   logic        eng_enable_o;
   logic        done_o;
   logic        err_o;
   logic        busy_o;
   logic [15:0] blocks_done_o;

   aes_multiblock_fsm dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .clear             (clear),
      .start_i           (start_i),
      .nb_blocks_i       (nb_blocks_i),
      .src_base_i        (src_base_i),
      .dst_base_i        (dst_base_i),
      .src_ready_start_i (src_ready_start_i),
      .snk_ready_start_i (snk_ready_start_i),
      .snk_done_i        (snk_done_i),
      .eng_block_done_i  (eng_block_done_i),
      .src_req_start_o   (src_req_start_o),
      .snk_req_start_o   (snk_req_start_o),
      .src_base_o        (src_base_o),
      .dst_base_o        (dst_base_o),
      .line_length_o     (line_length_o),
      .eng_clear_o       (eng_clear_o),
      .eng_start_o       (eng_start_o),
      .eng_enable_o      (eng_enable_o),
      .done_o            (done_o),
      .err_o             (err_o),
      .busy_o            (busy_o),
      .blocks_done_o     (blocks_done_o)
   );

   // expected job outcome, as seen by the slave at the done pulse
   typedef struct {
      logic        err;
      logic [15:0] blocks;
      logic [18:0] ll;
      logic [31:0] src;
      logic [31:0] dst;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding job
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && done_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_o=1 expected no job pending at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("done_err", 64'(err_o), 64'(e.err));
            chk("done_blocks", 64'(blocks_done_o), 64'(e.blocks));
            chk("done_line_length", 64'(line_length_o), 64'(e.ll));
            chk("done_src_base", 64'(src_base_o), 64'(e.src));
            chk("done_dst_base", 64'(dst_base_o), 64'(e.dst));
            $display("job done: err=%0d blocks=%0d line_length=%0d", err_o, blocks_done_o, line_length_o);
         end
      end
   end

   // pulse start in IDLE, then scramble the parameter inputs to prove they were latched
   task automatic start_only(input int n, input logic [31:0] s, input logic [31:0] d);
      @(negedge clk);
      start_i     = 1'b1;
      nb_blocks_i = 16'(n);
      src_base_i  = s;
      dst_base_i  = d;
      @(negedge clk);
      start_i     = 1'b0;
      nb_blocks_i = 16'($urandom);
      src_base_i  = $urandom;
      dst_base_i  = $urandom;
   endtask

   // raise src ready after sd cycles and snk ready after kd cycles; WORKING only once both are high
   task automatic handshake(input int sd, input int kd);
      int c;
      int mx;
      c  = 0;
      mx = (sd > kd) ? sd : kd;
      chk("req_start_both", 64'({src_req_start_o, snk_req_start_o, eng_start_o}), 64'h7);
      forever begin
         c++;
         src_ready_start_i = (c >= sd);
         snk_ready_start_i = (c >= kd);
         @(negedge clk);
         if (c >= mx) begin
            chk("enter_working", 64'({eng_enable_o, src_req_start_o, snk_req_start_o}), 64'h4);
            break;
         end
         chk("hold_starting", 64'({eng_enable_o, src_req_start_o, snk_req_start_o}), 64'h3);
      end
      src_ready_start_i = 1'b0;
      snk_ready_start_i = 1'b0;
   endtask

   // deliver cnt block_done pulses with random gaps; stray start pulses must be ignored
   task automatic give_blocks(input int cnt, input int n, input bit same);
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         eng_block_done_i = 1'b1;
         start_i          = 1'($urandom_range(0, 1));
         if (same && (i == n - 1)) snk_done_i = 1'b1;
         @(negedge clk);
         eng_block_done_i = 1'b0;
         snk_done_i       = 1'b0;
         start_i          = 1'b0;
         chk("progress", 64'(blocks_done_o), 64'(i + 1));
      end
   endtask

   task automatic wait_done(input int lim, output int waited);
      waited = 0;
      while (!done_o && waited < lim) begin
         @(negedge clk);
         waited++;
      end
      if (!done_o) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done_o expected one within %0d cycles", lim);
      end
   endtask

   // one complete job; stall >= 0 means the engine stops after that many blocks
   task automatic run_job(input int n, input int sd, input int kd, input int stall, input bit same);
      exp_t        e;
      logic [31:0] s;
      logic [31:0] d;
      int          w;
      s        = $urandom;
      d        = $urandom;
      e.err    = (n == 0) || (stall >= 0);
      e.blocks = (n == 0) ? 16'd0 : ((stall >= 0) ? 16'(stall) : 16'(n));
      e.ll     = 19'(n * 4);
      e.src    = s;
      e.dst    = d;
      exp_q.push_back(e);
      $display("job start: n=%0d src_dly=%0d snk_dly=%0d stall=%0d same=%0d", n, sd, kd, stall, same);
      start_only(n, s, d);
      if (n == 0) begin
         chk("n0_done_next_cycle", 64'(done_o), 64'd1);
         chk("n0_no_req", 64'({src_req_start_o, snk_req_start_o}), 64'd0);
      end else begin
         handshake(sd, kd);
         if (stall >= 0) begin
            give_blocks(stall, n, 1'b0);
            wait_done(1200, w);
            chk("wdog_window", 64'((w >= 1000) && (w <= 1100)), 64'd1);
         end else begin
            give_blocks(n, n, same);
            if (!same) begin
               repeat ($urandom_range(0, 4)) @(negedge clk);
               snk_done_i = 1'b1;
               @(negedge clk);
               snk_done_i = 1'b0;
            end
            wait_done(20, w);
         end
      end
      @(negedge clk);
      chk("idle_after_done", 64'({busy_o, eng_clear_o, done_o}), 64'h2);
   endtask

   // start a long job and get it into WORKING with a few blocks done
   task automatic start_abort_job();
      start_only(8, $urandom, $urandom);
      handshake(1, 1);
      give_blocks(3, 8, 1'b0);
   endtask

   initial begin
      reset_n           = 1'b0;
      clear             = 1'b0;
      start_i           = 1'b0;
      nb_blocks_i       = '0;
      src_base_i        = '0;
      dst_base_i        = '0;
      src_ready_start_i = 1'b0;
      snk_ready_start_i = 1'b0;
      snk_done_i        = 1'b0;
      eng_block_done_i  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({eng_clear_o, busy_o, done_o, err_o, src_req_start_o,
                                snk_req_start_o, eng_start_o, eng_enable_o}), 64'h80);
      chk("reset_blocks", 64'(blocks_done_o), 64'd0);
      reset_n = 1'b1;

      run_job(4, 3, 3, -1, 1'b0);
      run_job(0, 1, 1, -1, 1'b0);
      repeat (3) @(negedge clk);
      chk("err_sticky_in_idle", 64'(err_o), 64'd1);
      run_job(2, 2, 5, -1, 1'b0);
      run_job(1, 1, 1, -1, 1'b1);
      run_job(3, 1, 2, 1, 1'b0);

      // soft clear mid-job
      $display("job start: n=8 aborted by clear");
      start_abort_job();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_idle", 64'({busy_o, eng_clear_o, err_o}), 64'h2);
      chk("clear_blocks", 64'(blocks_done_o), 64'd0);
      repeat (5) @(negedge clk);
      run_job(5, 2, 1, -1, 1'b0);

      // asynchronous reset mid-job
      run_job(0, 1, 1, -1, 1'b0);
      $display("job start: n=8 aborted by reset");
      start_abort_job();
      #2 reset_n = 1'b0;
      #1;
      chk("reset_mid_idle", 64'({busy_o, eng_clear_o, err_o, eng_enable_o}), 64'h4);
      chk("reset_mid_blocks", 64'(blocks_done_o), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      run_job(8, 1, 3, -1, 1'b0);

      for (int j = 0; j < 10; j++) begin
         run_job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 4), -1,
                 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got simulation still running expected finish");
      $fatal(1, "global timeout");
   end

endmodule
